// File: rtl/fc8_mem_arbiter.sv
// fc8_mem_arbiter: N-master arbiter (fixed priority with starvation guard, or round robin) in front of one
// single-port memory; one access per cycle, completions routed back to the issuing master by ID.
module fc8_mem_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8,
  parameter int RD_LATENCY = 1,
  parameter int ARB_MODE = 0,
  parameter int MAX_HOLD = 8
) (
  input  logic                          master_clk,
  input  logic                          master_rst_n,
  input  logic [NUM_MASTERS-1:0]        req_valid,
  input  logic [NUM_MASTERS-1:0]        req_wr,
  input  logic [NUM_MASTERS*ADDR_W-1:0] req_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] req_wdata,
  output logic [NUM_MASTERS-1:0]        req_ready,
  output logic [NUM_MASTERS-1:0]        rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic                          mem_cs,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [2:0]                    grant_id
);
  localparam int N = NUM_MASTERS;
  localparam int IW = $clog2(N);
  localparam int D = RD_LATENCY + 1;
  logic [IW-1:0] rr_ptr, win, idx;
  logic [7:0] hold_cnt;
  logic [N-1:0] cand, holder;
  logic hit;
  logic [D-1:0] pipe_vld, pipe_wr;
  logic [IW-1:0] pipe_id [D];
  assign holder = N'(1) << grant_id;
  // The holder is masked only when it has used up its streak and someone else is waiting.
  always_comb begin
    cand = (ARB_MODE == 0 && MAX_HOLD > 0 && hold_cnt == 8'(MAX_HOLD) && |(req_valid & ~holder)) ? req_valid & ~holder : req_valid;
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'(ARB_MODE != 0 ? (int'(rr_ptr) + k) % N : k);
      if (!hit && cand[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
    req_ready = (hit && master_rst_n) ? N'(1) << win : '0;
  end
  always_ff @(posedge master_clk or negedge master_rst_n) begin
    if (!master_rst_n) begin
      rr_ptr <= '0;
      hold_cnt <= '0;
      grant_id <= '0;
      mem_cs <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      pipe_vld <= '0;
      pipe_wr <= '0;
      pipe_id <= '{default: '0};
    end else begin
      mem_cs <= hit;
      mem_wr_en <= hit & req_wr[win];
      pipe_vld <= {pipe_vld[D-2:0], hit};
      pipe_wr <= {pipe_wr[D-2:0], req_wr[win]};
      pipe_id[0] <= win;
      for (int k = D - 1; k > 0; k--) pipe_id[k] <= pipe_id[k-1];
      if (hit) begin
        mem_addr <= req_addr[win*ADDR_W +: ADDR_W];
        mem_wdata <= req_wdata[win*DATA_W +: DATA_W];
        grant_id <= 3'(win);
        rr_ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
        hold_cnt <= (3'(win) == grant_id && hold_cnt != 8'd0) ? ((hold_cnt == 8'(MAX_HOLD)) ? hold_cnt : hold_cnt + 8'd1) : 8'd1;
      end
    end
  end
  // Read data is forwarded straight from the memory in the cycle the completion pulses.
  assign rsp_valid = pipe_vld[D-1] ? N'(1) << pipe_id[D-1] : '0;
  assign rsp_rdata = (pipe_vld[D-1] && !pipe_wr[D-1]) ? mem_rdata : '0;
endmodule
